div_iter_rv: RTL
================

// Module: div_iter_rv
// PURPOSE
//   Parametrised iterative radix-2 divider for the M-extension execute stage.
//   Handles DIV/DIVU/REM/REMU with RISC-V divide-by-zero and signed-overflow results,
//   carries a writeback tag, and supports pipeline flush. One quotient bit per cycle;
//   the EX stage stalls on busy_o and writes back on valid_o.
// PARAMETERS
//   XLEN   32  operand/result width (>=8, even)
//   TAG_W  5   width of writeback tag (destination register index)
// PORTS
//   clk         in   1      clock
//   rst         in   1      synchronous reset, active-high
//   start_i     in   1      request; accepted only when busy_o==0 and flush_i==0
//   op_i        in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled at accept)
//   dividend_i  in   XLEN   rs1 value (sampled at accept)
//   divisor_i   in   XLEN   rs2 value (sampled at accept)
//   tag_i       in   TAG_W  writeback tag (sampled at accept)
//   flush_i     in   1      abort any operation in flight
//   busy_o      out  1      1 from cycle after accept until the cycle valid_o is high
//   valid_o     out  1      one-cycle pulse: result_o/tag_o valid
//   result_o    out  XLEN   quotient (DIV/DIVU) or remainder (REM/REMU)
//   tag_o       out  TAG_W  tag of the completed operation
// BEHAVIOUR
//   Reset: state IDLE; busy_o=0, valid_o=0, result_o=0, tag_o=0, internal regs 0.
//   Operands, op and tag are registered at accept; inputs may change afterwards.
//   States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//   IDLE: on accept, signed op -> take |dividend|,|divisor|; record neg_q =
//     sign(a)^sign(b), neg_r = sign(a) (signed ops only); count=XLEN-1 -> CALC.
//     Special cases bypass CALC and go straight to DONE:
//       divisor==0 : quotient = all ones, remainder = dividend (both signednesses)
//       signed, dividend==2^(XLEN-1), divisor==-1 : quotient = dividend, remainder=0
//   CALC: restoring step per cycle: rem' = {rem,a[count]}; if rem'>=b then
//     rem'-=b, q bit=1. XLEN cycles (count down to 0), then FIX. Remainder
//     register is XLEN+1 bits to avoid overflow on the shift.
//   FIX: negate quotient if neg_q, negate remainder if neg_r; select by op -> DONE.
//   DONE: valid_o=1, result_o/tag_o updated, busy_o=0 this cycle -> IDLE.
//   Latency (accept cycle = 0): normal op valid_o at cycle XLEN+2; special cases
//     valid_o at cycle 1. Throughput: a new start_i is accepted in the DONE cycle's
//     following cycle (IDLE); start_i while busy_o=1 is ignored, not queued.
//   result_o/tag_o hold their last value between valid_o pulses.
//   flush_i: in any state, next state IDLE, busy_o=0, no valid_o for the aborted op;
//     flush_i and start_i in the same cycle -> flush wins, start dropped;
//     flush_i in DONE cycle -> valid_o of that cycle is suppressed, result_o unchanged.
//   rst mid-operation: identical to reset values; operation lost silently.
//   Unsigned ops never negate; REMU by zero returns dividend unchanged.
// STRUCTURE
//   Shared package rv_div_pkg: op encodings (OP_DIV..OP_REMU), state encoding,
//     div-by-zero quotient constant '1.
//   Sub-module div_iter_step (combinational): {rem_in, a_bit, b} -> {rem_out, q_bit};
//     one instance used by CALC. Sign handling and FSM stay in div_iter_rv.
// TESTING (XLEN=32)
//   DIV  -7 / 2, tag 3       -> result 0xFFFFFFFD (-3), tag_o 3, valid at cycle 34
//   REM  -7 / 2 ; REMU 7 / 0 -> 0xFFFFFFFF (-1) ; 0x00000007 at cycle 1
//   DIV  0x80000000 / -1 ; DIVU 5 / 0 -> 0x80000000 ; 0xFFFFFFFF, both valid at cycle 1
//   DIVU 0xFFFFFFFF / 1 ; REM 0x80000000 / -1 -> 0xFFFFFFFF at cycle 34 ; 0
//   Flush at cycle 10 of DIV 100/7, start on same cycle -> no valid_o, busy_o=0
//     next cycle, start dropped; following DIV 100/7 -> 14, REM -> 2
//   start_i held high while busy, rst at cycle 5 -> only one result per accept;
//     after rst all outputs 0, next op completes normally
//   Random: 10k signed/unsigned ops vs reference model, incl. XLEN=16 build

Source files
------------

// File: rtl/rv_div_pkg.sv
// Shared encodings for the iterative M-extension divider.
// Op codes, FSM states and the divide-by-zero quotient fill.
package rv_div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  // Quotient on divide-by-zero is all ones at any width.
  localparam logic DIVZ_BIT = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step: shift in a dividend bit,
// subtract the divisor when it fits.
module div_iter_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic            a_bit_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_bit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] b_ext;

  always_comb begin
    shifted = (rem_i << 1) | {{XLEN{1'b0}}, a_bit_i};
    b_ext   = {1'b0, b_i};
    q_bit_o = (shifted >= b_ext);
    rem_o   = q_bit_o ? (shifted - b_ext) : shifted;
  end

endmodule

// File: rtl/div_iter_rv.sv
// Iterative radix-2 divider for DIV/DIVU/REM/REMU with
// RISC-V corner-case results, writeback tag and flush.
module div_iter_rv
  import rv_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [XLEN-1:0]  dividend_i,
  input  logic [XLEN-1:0]  divisor_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [XLEN-1:0]  result_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d, q_q, q_d;
  logic [XLEN-1:0]  res_q, res_d, out_q, out_d;
  logic [XLEN:0]    rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             isrem_q, isrem_d;
  logic [TAG_W-1:0] tag_q, tag_d, tago_q, tago_d;

  logic            accept, sgn, a_neg, b_neg, step_q;
  logic [XLEN:0]   step_rem;
  logic [XLEN-1:0] a_abs, b_abs, quot, remv;

  div_iter_step #(.XLEN(XLEN)) u_step (
    .rem_i   (rem_q),
    .a_bit_i (a_q[cnt_q]),
    .b_i     (b_q),
    .rem_o   (step_rem),
    .q_bit_o (step_q)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    q_d     = q_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    isrem_d = isrem_q;
    tag_d   = tag_q;
    res_d   = res_q;
    out_d   = out_q;
    tago_d  = tago_q;

    accept = (state_q == S_IDLE) && start_i && !flush_i;
    sgn    = ~op_i[0];
    a_neg  = sgn & dividend_i[XLEN-1];
    b_neg  = sgn & divisor_i[XLEN-1];
    a_abs  = a_neg ? -dividend_i : dividend_i;
    b_abs  = b_neg ? -divisor_i : divisor_i;
    quot   = qneg_q ? -q_q : q_q;
    remv   = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d   = tag_i;
          isrem_d = op_i[1];
          a_d     = a_abs;
          b_d     = b_abs;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          rem_d   = '0;
          q_d     = '0;
          cnt_d   = CW'(XLEN - 1);
          if (divisor_i == '0) begin
            res_d   = op_i[1] ? dividend_i : {XLEN{DIVZ_BIT}};
            state_d = S_DONE;
          end else if (sgn && dividend_i == MIN_NEG
                       && divisor_i == '1) begin
            res_d   = op_i[1] ? '0 : dividend_i;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = step_rem;
        q_d   = {q_q[XLEN-2:0], step_q};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        res_d   = isrem_q ? remv : quot;
        state_d = S_DONE;
      end
      S_DONE: begin
        out_d   = res_q;
        tago_d  = tag_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flush aborts everything, including the DONE-cycle commit.
    if (flush_i) begin
      state_d = S_IDLE;
      out_d   = out_q;
      tago_d  = tago_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
      tag_q   <= '0;
      res_q   <= '0;
      out_q   <= '0;
      tago_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      isrem_q <= isrem_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
      out_q   <= out_d;
      tago_q  <= tago_d;
    end
  end

  assign busy_o   = (state_q == S_CALC) || (state_q == S_FIX);
  assign valid_o  = (state_q == S_DONE) && !flush_i;
  assign result_o = valid_o ? res_q : out_q;
  assign tag_o    = valid_o ? tag_q : tago_q;

endmodule
